axi_slice_pipe: RTL and testbench
=================================

# axi_slice_pipe

Parametrised AXI4 full-interface pipeline slice for the DMA master path: sits between the DMA master port and the interconnect/bench slave, buffering each of the five AXI channels (AW, W, B, AR, R) in an independently sized FIFO. It replaces hand-flattened, zero-latency struct pass-through with registered, full-throughput channel isolation and optional outstanding-transaction limiting. It operates on the shared `s_axi_mosi_t` / `s_axi_miso_t` structs.

## Interface
- `AW_DEPTH`, default 2: AW channel FIFO entries; 0 = combinational pass-through; otherwise power of two ≥2.
- `W_DEPTH`, default 4: W channel FIFO entries; same rules.
- `B_DEPTH`, default 2: B channel FIFO entries; same rules.
- `AR_DEPTH`, default 2: AR channel FIFO entries; same rules.
- `R_DEPTH`, default 4: R channel FIFO entries; same rules.
- `MAX_OT`, default 8: outstanding-transaction limit per direction (1..255); used only with `AXI_SLICE_OT_LIMIT_EN`.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `s_mosi` in `s_axi_mosi_t`: upstream request (from DMA master).
- `s_miso` out `s_axi_miso_t`: upstream response.
- `m_mosi` out `s_axi_mosi_t`: downstream request.
- `m_miso` in `s_axi_miso_t`: downstream response.
- `wr_ot` out 8: current write transactions outstanding.
- `rd_ot` out 8: current read transactions outstanding.
- `idle` out 1: all FIFOs empty and both OT counts zero.

## Operation
- AW, W, AR flow s_mosi→m_mosi; B, R flow m_miso→s_miso. Each channel: payload = all struct fields of that channel excluding valid/ready.
- Channel with depth N>0: push on input valid&ready, pop on output valid&ready; input ready = !full; output valid = !empty; output payload = head entry. Simultaneous push/pop when full: push refused (ready low), pop proceeds. Push/pop when neither full nor empty: occupancy unchanged.
- Depth 0: valid, ready, payload wired straight through; no state.
- Pointers: log2(N) bits plus one wrap bit; full = equal index, differing wrap bit; empty = pointers equal. Wrap-around is natural binary rollover.
- No reordering, no ID interpretation, no burst splitting; beats pass verbatim, wlast/rlast included.
- `wr_ot`: +1 on upstream AW handshake, −1 on upstream B handshake, unchanged when both same cycle. `rd_ot`: +1 on upstream AR handshake, −1 on upstream R handshake with rlast=1. Saturating, never wrap.
- Reset (mid-operation included): all FIFOs emptied immediately; in-flight beats discarded; counters cleared.

## Timing
- Reset values: every valid in s_miso/m_mosi = 0, every ready = 0 while `rst` low; all payload fields 0; `wr_ot`=`rd_ot`=0; `idle`=1.
- First cycle after `rst` deassertion: readys reflect !full (high).
- Depth N>0: 1 cycle latency input handshake → output valid; sustains 1 beat/cycle for N≥2 with downstream ready continuously high.
- Readys depend only on registered state (no valid→ready combinational path) for N>0.
- Depth 0: 0 latency, full combinational paths both directions.
- `wr_ot`/`rd_ot`/`idle` registered, update the cycle after the causing handshake.

## Configuration
- `AXI_SLICE_OT_LIMIT_EN` defined: upstream awready forced 0 when `wr_ot`==`MAX_OT`; upstream arready forced 0 when `rd_ot`==`MAX_OT`; a same-cycle B/last-R does not lift the block until the next cycle.
- Undefined: no limiting; counters still track for `wr_ot`/`rd_ot`/`idle`; `MAX_OT` ignored.

## Structure
- Shared package: `s_axi_mosi_t`, `s_axi_miso_t`, per-channel payload typedefs (`axi_aw_pld_t`, `axi_w_pld_t`, `axi_b_pld_t`, `axi_ar_pld_t`, `axi_r_pld_t`), `AXI_SLICE_OT_W` = 8.
- One sub-module `axi_slice_fifo` (params `DEPTH`, payload type), instantiated five times; generate-branch for DEPTH=0 bypass; elaboration error on DEPTH=1 or non-power-of-two.

## Test plan
- Reset: hold `rst` low with s_mosi.awvalid=1 → all valids/readys 0, `idle`=1; release → awready=1 next cycle, m_mosi.awvalid=1 one cycle later.
- Throughput: 16-beat write burst (awlen=15), m readys always 1, W_DEPTH=4 → 16 W beats out in 16 consecutive cycles, first 1 cycle after first input, wlast only on beat 16.
- Backpressure/full: m_miso.wready=0, push 5 beats into W_DEPTH=4 → wready drops after 4th; release → beats 1–5 emerge in order, data intact.
- OT limit (macro on, MAX_OT=2): issue 3 ARs, no R returned → 3rd arready held 0, `rd_ot`=2; return R with rlast=1 → `rd_ot`=1, 3rd AR accepted next cycle.
- Simultaneous: AW and B handshakes same cycle at `wr_ot`=3 → `wr_ot` stays 3.
- Reset mid-burst: assert `rst` after 2 of 8 R beats → all FIFOs empty, `rd_ot`=0, no stale beats after release.

Source files
------------

// File: rtl/axi_slice_pipe_pkg.sv
// Shared AXI4 channel structs and helpers for the DMA-path pipeline slice.
package axi_slice_pipe_pkg;

    localparam int unsigned AXI_SLICE_OT_W = 8;
    localparam int unsigned AXI_ID_W       = 4;
    localparam int unsigned AXI_ADDR_W     = 32;
    localparam int unsigned AXI_DATA_W     = 32;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   awid;
        logic [AXI_ADDR_W-1:0] awaddr;
        logic [7:0]            awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
    } axi_aw_pld_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
    } axi_w_pld_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] bid;
        logic [1:0]          bresp;
    } axi_b_pld_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   arid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
    } axi_ar_pld_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   rid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
    } axi_r_pld_t;

    typedef struct packed {
        axi_aw_pld_t aw;
        logic        awvalid;
        axi_w_pld_t  w;
        logic        wvalid;
        logic        bready;
        axi_ar_pld_t ar;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        axi_b_pld_t  b;
        logic        bvalid;
        logic        arready;
        axi_r_pld_t  r;
        logic        rvalid;
    } s_axi_miso_t;

    // Saturating outstanding counter step; simultaneous inc/dec cancel out.
    function automatic logic [AXI_SLICE_OT_W-1:0] ot_next(
        input logic [AXI_SLICE_OT_W-1:0] cur,
        input logic                      inc,
        input logic                      dec
    );
        ot_next = cur;
        if (inc && !dec && (cur != '1)) begin
            ot_next = cur + 1'b1;
        end else if (dec && !inc && (cur != '0)) begin
            ot_next = cur - 1'b1;
        end
    endfunction

endpackage

// File: rtl/axi_slice_pipe_fifo.sv
// Single AXI channel buffer: DEPTH=0 is a wire-through, otherwise a power-of-two
// FIFO whose ready depends only on registered state.
module axi_slice_fifo
    import axi_slice_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         PLD_T = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  PLD_T in_pld_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output PLD_T out_pld_o,
    output logic empty_o
);

    if (DEPTH == 0) begin : g_bypass
        assign in_ready_o  = out_ready_i;
        assign out_valid_o = in_valid_i;
        assign out_pld_o   = in_pld_i;
        assign empty_o     = 1'b1;
    end else if ((DEPTH == 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axi_slice_fifo: DEPTH must be 0 or a power of two >= 2");
        assign in_ready_o  = 1'b0;
        assign out_valid_o = 1'b0;
        assign out_pld_o   = '0;
        assign empty_o     = 1'b1;
    end else begin : g_fifo
        localparam int unsigned IW = $clog2(DEPTH);

        PLD_T        mem_q [DEPTH];
        logic [IW:0] wr_q, wr_d, rd_q, rd_d;
        logic        live_q;
        logic        full, push, pop;

        // live_q holds ready low through reset and releases it on the first edge after.
        assign full        = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
        assign empty_o     = (wr_q == rd_q);
        assign in_ready_o  = live_q && !full;
        assign out_valid_o = !empty_o;
        assign out_pld_o   = mem_q[rd_q[IW-1:0]];
        assign push        = in_valid_i && in_ready_o;
        assign pop         = out_valid_o && out_ready_i;

        always_comb begin
            wr_d = wr_q;
            rd_d = rd_q;
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_q   <= '0;
                rd_q   <= '0;
                live_q <= 1'b0;
                for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            end else begin
                wr_q   <= wr_d;
                rd_q   <= rd_d;
                live_q <= 1'b1;
                if (push) mem_q[wr_q[IW-1:0]] <= in_pld_i;
            end
        end
    end

endmodule

// File: rtl/axi_slice_pipe.sv
// AXI4 five-channel pipeline slice with outstanding-transaction tracking.
// Define AXI_SLICE_OT_LIMIT_EN to stall AW/AR once MAX_OT transactions are open.
module axi_slice_pipe
    import axi_slice_pipe_pkg::*;
#(
    parameter int unsigned AW_DEPTH = 2,
    parameter int unsigned W_DEPTH  = 4,
    parameter int unsigned B_DEPTH  = 2,
    parameter int unsigned AR_DEPTH = 2,
    parameter int unsigned R_DEPTH  = 4,
    parameter int unsigned MAX_OT   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  s_axi_mosi_t               s_mosi,
    output s_axi_miso_t               s_miso,
    output s_axi_mosi_t               m_mosi,
    input  s_axi_miso_t               m_miso,
    output logic [AXI_SLICE_OT_W-1:0] wr_ot,
    output logic [AXI_SLICE_OT_W-1:0] rd_ot,
    output logic                      idle
);

    if ((MAX_OT < 1) || (MAX_OT > 255)) begin : g_bad_max_ot
        $error("axi_slice_pipe: MAX_OT must be 1..255");
    end

    logic [AXI_SLICE_OT_W-1:0] wr_ot_q, wr_ot_d, rd_ot_q, rd_ot_d;
    logic aw_blk, ar_blk, aw_acc, b_acc, ar_acc, r_last_acc;
    logic aw_in_rdy, w_in_rdy, b_in_rdy, ar_in_rdy, r_in_rdy;
    logic aw_out_vld, w_out_vld, b_out_vld, ar_out_vld, r_out_vld;
    logic aw_empty, w_empty, b_empty, ar_empty, r_empty;
    axi_aw_pld_t aw_out;
    axi_w_pld_t  w_out;
    axi_b_pld_t  b_out;
    axi_ar_pld_t ar_out;
    axi_r_pld_t  r_out;

`ifdef AXI_SLICE_OT_LIMIT_EN
    assign aw_blk = (wr_ot_q == AXI_SLICE_OT_W'(MAX_OT));
    assign ar_blk = (rd_ot_q == AXI_SLICE_OT_W'(MAX_OT));
`else
    assign aw_blk = 1'b0;
    assign ar_blk = 1'b0;
`endif

    axi_slice_fifo #(.DEPTH(AW_DEPTH), .PLD_T(axi_aw_pld_t)) u_aw (
        .clk_i(clk), .rst_ni(rst),
        .in_valid_i(s_mosi.awvalid && !aw_blk), .in_ready_o(aw_in_rdy), .in_pld_i(s_mosi.aw),
        .out_valid_o(aw_out_vld), .out_ready_i(m_miso.awready), .out_pld_o(aw_out),
        .empty_o(aw_empty)
    );

    axi_slice_fifo #(.DEPTH(W_DEPTH), .PLD_T(axi_w_pld_t)) u_w (
        .clk_i(clk), .rst_ni(rst),
        .in_valid_i(s_mosi.wvalid), .in_ready_o(w_in_rdy), .in_pld_i(s_mosi.w),
        .out_valid_o(w_out_vld), .out_ready_i(m_miso.wready), .out_pld_o(w_out),
        .empty_o(w_empty)
    );

    axi_slice_fifo #(.DEPTH(B_DEPTH), .PLD_T(axi_b_pld_t)) u_b (
        .clk_i(clk), .rst_ni(rst),
        .in_valid_i(m_miso.bvalid), .in_ready_o(b_in_rdy), .in_pld_i(m_miso.b),
        .out_valid_o(b_out_vld), .out_ready_i(s_mosi.bready), .out_pld_o(b_out),
        .empty_o(b_empty)
    );

    axi_slice_fifo #(.DEPTH(AR_DEPTH), .PLD_T(axi_ar_pld_t)) u_ar (
        .clk_i(clk), .rst_ni(rst),
        .in_valid_i(s_mosi.arvalid && !ar_blk), .in_ready_o(ar_in_rdy), .in_pld_i(s_mosi.ar),
        .out_valid_o(ar_out_vld), .out_ready_i(m_miso.arready), .out_pld_o(ar_out),
        .empty_o(ar_empty)
    );

    axi_slice_fifo #(.DEPTH(R_DEPTH), .PLD_T(axi_r_pld_t)) u_r (
        .clk_i(clk), .rst_ni(rst),
        .in_valid_i(m_miso.rvalid), .in_ready_o(r_in_rdy), .in_pld_i(m_miso.r),
        .out_valid_o(r_out_vld), .out_ready_i(s_mosi.rready), .out_pld_o(r_out),
        .empty_o(r_empty)
    );

    always_comb begin
        m_mosi         = '0;
        m_mosi.aw      = aw_out;
        m_mosi.awvalid = aw_out_vld;
        m_mosi.w       = w_out;
        m_mosi.wvalid  = w_out_vld;
        m_mosi.bready  = b_in_rdy;
        m_mosi.ar      = ar_out;
        m_mosi.arvalid = ar_out_vld;
        m_mosi.rready  = r_in_rdy;

        s_miso         = '0;
        s_miso.awready = aw_in_rdy && !aw_blk;
        s_miso.wready  = w_in_rdy;
        s_miso.b       = b_out;
        s_miso.bvalid  = b_out_vld;
        s_miso.arready = ar_in_rdy && !ar_blk;
        s_miso.r       = r_out;
        s_miso.rvalid  = r_out_vld;
    end

    // Counters track upstream handshakes only, so they reflect what the master sees.
    assign aw_acc     = s_mosi.awvalid && aw_in_rdy && !aw_blk;
    assign b_acc      = b_out_vld && s_mosi.bready;
    assign ar_acc     = s_mosi.arvalid && ar_in_rdy && !ar_blk;
    assign r_last_acc = r_out_vld && s_mosi.rready && r_out.rlast;

    always_comb begin
        wr_ot_d = ot_next(wr_ot_q, aw_acc, b_acc);
        rd_ot_d = ot_next(rd_ot_q, ar_acc, r_last_acc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ot_q <= '0;
            rd_ot_q <= '0;
        end else begin
            wr_ot_q <= wr_ot_d;
            rd_ot_q <= rd_ot_d;
        end
    end

    assign wr_ot = wr_ot_q;
    assign rd_ot = rd_ot_q;
    assign idle  = aw_empty && w_empty && b_empty && ar_empty && r_empty
                   && (wr_ot_q == '0) && (rd_ot_q == '0);

endmodule

// File: tb/tb_axi_slice_pipe.sv
// Self-checking bench for axi_slice_pipe: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_axi_slice_pipe;
    import axi_slice_pipe_pkg::*;

    localparam int unsigned AW_D = 2, W_D = 4, B_D = 2, AR_D = 2, R_D = 4, MAX_OT = 2;
`ifdef AXI_SLICE_OT_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    s_axi_mosi_t s_mosi, m_mosi;
    s_axi_miso_t s_miso, m_miso;
    logic [7:0]  wr_ot, rd_ot;
    logic        idle;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    axi_slice_pipe #(
        .AW_DEPTH(AW_D), .W_DEPTH(W_D), .B_DEPTH(B_D),
        .AR_DEPTH(AR_D), .R_DEPTH(R_D), .MAX_OT(MAX_OT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_mosi(s_mosi), .s_miso(s_miso),
        .m_mosi(m_mosi), .m_miso(m_miso),
        .wr_ot(wr_ot), .rd_ot(rd_ot), .idle(idle)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_mosi = '0;
        m_miso = '0;
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        logic [63:0] t;
        axi_aw_pld_t p;
        t = {$urandom(), $urandom()};
        p = t[$bits(axi_aw_pld_t)-1:0];
        s_mosi = '0;
        m_miso = '0;
        rst = 1'b0;
        s_mosi.awvalid = 1'b1;
        s_mosi.aw = p;
        cyc();
        cyc();
        n_checks++;
        if ({m_mosi.awvalid, m_mosi.wvalid, m_mosi.arvalid, s_miso.bvalid, s_miso.rvalid} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_valids got=%b exp=00000",
                     {m_mosi.awvalid, m_mosi.wvalid, m_mosi.arvalid, s_miso.bvalid, s_miso.rvalid});
        end
        n_checks++;
        if ({s_miso.awready, s_miso.wready, s_miso.arready, m_mosi.bready, m_mosi.rready} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_readys got=%b exp=00000",
                     {s_miso.awready, s_miso.wready, s_miso.arready, m_mosi.bready, m_mosi.rready});
        end
        n_checks++;
        if (m_mosi.aw !== '0 || s_miso.r !== '0) begin
            n_errors++;
            $display("FAIL reset_payload got aw=%0h r=%0h exp=0", m_mosi.aw, s_miso.r);
        end
        n_checks++;
        if (idle !== 1'b1 || wr_ot !== 8'd0 || rd_ot !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_idle_ot got idle=%b wr=%0d rd=%0d exp 1/0/0", idle, wr_ot, rd_ot);
        end
        rst = 1'b1;
        cyc();
        n_checks++;
        if (s_miso.awready !== 1'b1 || m_mosi.awvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL release_awready got rdy=%b vld=%b exp 1/0", s_miso.awready, m_mosi.awvalid);
        end
        cyc();
        s_mosi.awvalid = 1'b0;
        n_checks++;
        if (m_mosi.awvalid !== 1'b1 || m_mosi.aw !== p) begin
            n_errors++;
            $display("FAIL release_aw_out got vld=%b aw=%0h exp 1/%0h", m_mosi.awvalid, m_mosi.aw, p);
        end
        n_checks++;
        if (wr_ot !== 8'd1 || idle !== 1'b0) begin
            n_errors++;
            $display("FAIL release_wr_ot got wr=%0d idle=%b exp 1/0", wr_ot, idle);
        end
    endtask

    task automatic test_throughput();
        logic [31:0] d [16];
        int sent, got, first_out, last_out, gaps, bad;
        bit rdy_ok;
        do_reset();
        foreach (d[i]) d[i] = $urandom();
        sent = 0; got = 0; first_out = -1; last_out = -1; gaps = 0; bad = 0; rdy_ok = 1'b1;
        m_miso.awready = 1'b1;
        m_miso.wready  = 1'b1;
        s_mosi.awvalid = 1'b1;
        s_mosi.aw = '{awid: 4'h3, awaddr: 32'h1000, awlen: 8'd15, awsize: 3'd2, awburst: 2'd1};
        for (int c = 0; c < 30; c++) begin
            if (c == 1) begin
                s_mosi.awvalid = 1'b0;
                n_checks++;
                if (m_mosi.awvalid !== 1'b1 || m_mosi.aw.awlen !== 8'd15) begin
                    n_errors++;
                    $display("FAIL burst_aw got vld=%b len=%0d exp 1/15", m_mosi.awvalid, m_mosi.aw.awlen);
                end
            end
            if (m_mosi.wvalid === 1'b1) begin
                if (got < 16) begin
                    if (m_mosi.w.wdata !== d[got] || m_mosi.w.wlast !== (got == 15)) bad++;
                end else begin
                    bad++;
                end
                if (got == 0) first_out = c;
                else if (c != last_out + 1) gaps++;
                last_out = c;
                got++;
            end
            if (sent < 16) begin
                s_mosi.wvalid = 1'b1;
                s_mosi.w = '{wdata: d[sent], wstrb: '1, wlast: (sent == 15)};
                if (s_miso.wready === 1'b1) sent++;
                else rdy_ok = 1'b0;
            end else begin
                s_mosi.wvalid = 1'b0;
            end
            cyc();
        end
        n_checks++;
        if (got !== 16 || bad !== 0) begin
            n_errors++;
            $display("FAIL burst_beats got=%0d bad=%0d exp 16/0", got, bad);
        end
        n_checks++;
        if (first_out !== 1 || gaps !== 0) begin
            n_errors++;
            $display("FAIL burst_timing got first=%0d gaps=%0d exp 1/0", first_out, gaps);
        end
        n_checks++;
        if (rdy_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL burst_wready got=0 exp=1 throughout");
        end
        m_miso.bvalid = 1'b1;
        m_miso.b = '{bid: 4'h3, bresp: 2'd0};
        s_mosi.bready = 1'b1;
        cyc();
        m_miso.bvalid = 1'b0;
        n_checks++;
        if (s_miso.bvalid !== 1'b1 || s_miso.b.bid !== 4'h3) begin
            n_errors++;
            $display("FAIL burst_b got vld=%b id=%0h exp 1/3", s_miso.bvalid, s_miso.b.bid);
        end
        cyc();
        n_checks++;
        if (wr_ot !== 8'd0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL burst_done got wr=%0d idle=%b exp 0/1", wr_ot, idle);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d [5];
        logic [7:0] hist;
        int acc, got, bad;
        do_reset();
        foreach (d[i]) d[i] = $urandom();
        acc = 0; got = 0; bad = 0; hist = '0;
        m_miso.wready = 1'b0;
        for (int c = 0; c < 28; c++) begin
            if (c == 8) begin
                n_checks++;
                if (acc !== 4 || hist !== 8'b0000_1111 || m_mosi.wvalid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL full_stall got acc=%0d hist=%b vld=%b exp 4/00001111/1", acc, hist, m_mosi.wvalid);
                end
                m_miso.wready = 1'b1;
            end
            if (c < 8) hist[c] = s_miso.wready;
            if (m_miso.wready && m_mosi.wvalid === 1'b1) begin
                if (got >= 5 || m_mosi.w.wdata !== d[got] || m_mosi.w.wlast !== (got == 4)) bad++;
                got++;
            end
            if (acc < 5) begin
                s_mosi.wvalid = 1'b1;
                s_mosi.w = '{wdata: d[acc], wstrb: '1, wlast: (acc == 4)};
                if (s_miso.wready === 1'b1) acc++;
            end else begin
                s_mosi.wvalid = 1'b0;
            end
            cyc();
        end
        n_checks++;
        if (got !== 5 || bad !== 0) begin
            n_errors++;
            $display("FAIL full_drain got beats=%0d bad=%0d exp 5/0", got, bad);
        end
    endtask

    task automatic test_ot_limit();
        int acc, exp_ot;
        do_reset();
        acc = 0;
        m_miso.arready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            s_mosi.arvalid = (acc < 3);
            s_mosi.ar = '{arid: 4'(acc), araddr: 32'h2000 + 32'(acc), arlen: 8'd0, arsize: 3'd2, arburst: 2'd1};
            if (s_mosi.arvalid && s_miso.arready === 1'b1) acc++;
            cyc();
        end
        exp_ot = LIM ? 2 : 3;
        n_checks++;
        if (acc !== exp_ot || rd_ot !== 8'(exp_ot)) begin
            n_errors++;
            $display("FAIL ot_fill got acc=%0d rd_ot=%0d exp %0d", acc, rd_ot, exp_ot);
        end
        n_checks++;
        if (s_miso.arready !== !LIM) begin
            n_errors++;
            $display("FAIL ot_block got arready=%b exp=%b", s_miso.arready, !LIM);
        end
        s_mosi.rready = 1'b1;
        m_miso.rvalid = 1'b1;
        m_miso.r = '{rid: 4'h0, rdata: 32'hA5A5_0001, rresp: 2'd0, rlast: 1'b0};
        cyc();
        m_miso.r = '{rid: 4'h0, rdata: 32'hA5A5_0002, rresp: 2'd0, rlast: 1'b1};
        cyc();
        m_miso.rvalid = 1'b0;
        n_checks++;
        if (rd_ot !== 8'(exp_ot) || s_miso.arready !== !LIM || s_miso.r.rlast !== 1'b1) begin
            n_errors++;
            $display("FAIL ot_nonlast got rd_ot=%0d arready=%b rlast=%b exp %0d/%b/1",
                     rd_ot, s_miso.arready, s_miso.r.rlast, exp_ot, !LIM);
        end
        cyc();
        n_checks++;
        if (rd_ot !== 8'(exp_ot - 1) || s_miso.arready !== 1'b1) begin
            n_errors++;
            $display("FAIL ot_release got rd_ot=%0d arready=%b exp %0d/1", rd_ot, s_miso.arready, exp_ot - 1);
        end
        cyc();
        s_mosi.arvalid = 1'b0;
        n_checks++;
        if (rd_ot !== 8'(LIM ? 2 : 2)) begin
            n_errors++;
            $display("FAIL ot_third_ar got rd_ot=%0d exp 2", rd_ot);
        end
    endtask

    task automatic test_simultaneous();
        int acc, lvl;
        do_reset();
        lvl = LIM ? int'(MAX_OT) - 1 : 3;
        acc = 0;
        m_miso.awready = 1'b1;
        for (int c = 0; c < 12 && acc < lvl; c++) begin
            s_mosi.awvalid = 1'b1;
            s_mosi.aw.awid = 4'(c);
            if (s_miso.awready === 1'b1) acc++;
            cyc();
        end
        s_mosi.awvalid = 1'b0;
        m_miso.bvalid = 1'b1;
        m_miso.b = '{bid: 4'h1, bresp: 2'd0};
        cyc();
        m_miso.bvalid = 1'b0;
        cyc();
        n_checks++;
        if (wr_ot !== 8'(lvl) || s_miso.bvalid !== 1'b1 || s_miso.awready !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_setup got wr=%0d bvld=%b awrdy=%b exp %0d/1/1", wr_ot, s_miso.bvalid, s_miso.awready, lvl);
        end
        s_mosi.bready  = 1'b1;
        s_mosi.awvalid = 1'b1;
        cyc();
        s_mosi.awvalid = 1'b0;
        n_checks++;
        if (wr_ot !== 8'(lvl)) begin
            n_errors++;
            $display("FAIL simul_hold got wr=%0d exp %0d", wr_ot, lvl);
        end
        cyc();
        n_checks++;
        if (wr_ot !== 8'(lvl) || s_miso.bvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_after got wr=%0d bvld=%b exp %0d/0", wr_ot, s_miso.bvalid, lvl);
        end
    endtask

    task automatic test_reset_mid();
        int got, k, stale;
        do_reset();
        m_miso.arready = 1'b1;
        s_mosi.arvalid = 1'b1;
        cyc();
        s_mosi.arvalid = 1'b0;
        got = 0; k = 0; stale = 0;
        s_mosi.rready = 1'b1;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (s_miso.rvalid === 1'b1) got++;
            m_miso.rvalid = (k < 8);
            m_miso.r = '{rid: 4'h0, rdata: 32'hBEEF_0000 + 32'(k), rresp: 2'd0, rlast: (k == 7)};
            if (m_miso.rvalid && m_mosi.rready === 1'b1) k++;
            cyc();
        end
        n_checks++;
        if (got !== 2 || rd_ot !== 8'd1) begin
            n_errors++;
            $display("FAIL mid_pre got beats=%0d rd_ot=%0d exp 2/1", got, rd_ot);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (s_miso.rvalid !== 1'b0 || m_mosi.rready !== 1'b0 || rd_ot !== 8'd0 || idle !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset got rvld=%b rrdy=%b rd_ot=%0d idle=%b exp 0/0/0/1",
                     s_miso.rvalid, m_mosi.rready, rd_ot, idle);
        end
        s_mosi = '0;
        m_miso = '0;
        s_mosi.rready = 1'b1;
        cyc();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (s_miso.rvalid !== 1'b0 || idle !== 1'b1) stale++;
        end
        n_checks++;
        if (stale !== 0) begin
            n_errors++;
            $display("FAIL mid_stale got stale_cycles=%0d exp 0", stale);
        end
    endtask

    task automatic test_random();
        axi_aw_pld_t awq[$], aw_v;
        axi_w_pld_t  wq[$],  w_v;
        axi_b_pld_t  bq[$],  b_v;
        axi_ar_pld_t arq[$], ar_v;
        axi_r_pld_t  rq[$],  r_v;
        bit aw_p, w_p, b_p, ar_p, r_p;
        bit e_awr, e_wr, e_br, e_arr, e_rr, h_aw, h_w, h_b, h_ar, h_r, h_bu, h_ru;
        int wr_m, rd_m;
        logic [63:0] t;
        do_reset();
        aw_p = 0; w_p = 0; b_p = 0; ar_p = 0; r_p = 0; wr_m = 0; rd_m = 0;
        aw_v = '0; w_v = '0; b_v = '0; ar_v = '0; r_v = '0;
        for (int c = 0; c < 600; c++) begin
            e_awr = (awq.size() < AW_D) && !(LIM && wr_m == int'(MAX_OT));
            e_arr = (arq.size() < AR_D) && !(LIM && rd_m == int'(MAX_OT));
            e_wr  = wq.size() < W_D;
            e_br  = bq.size() < B_D;
            e_rr  = rq.size() < R_D;
            n_checks++;
            if ({s_miso.awready, s_miso.wready, m_mosi.bready, s_miso.arready, m_mosi.rready} !==
                {e_awr, e_wr, e_br, e_arr, e_rr}) begin
                n_errors++;
                $display("FAIL rnd_ready c=%0d got=%b exp=%b", c,
                         {s_miso.awready, s_miso.wready, m_mosi.bready, s_miso.arready, m_mosi.rready},
                         {e_awr, e_wr, e_br, e_arr, e_rr});
            end
            n_checks++;
            if ({m_mosi.awvalid, m_mosi.wvalid, s_miso.bvalid, m_mosi.arvalid, s_miso.rvalid} !==
                {awq.size() != 0, wq.size() != 0, bq.size() != 0, arq.size() != 0, rq.size() != 0}) begin
                n_errors++;
                $display("FAIL rnd_valid c=%0d got=%b exp=%b", c,
                         {m_mosi.awvalid, m_mosi.wvalid, s_miso.bvalid, m_mosi.arvalid, s_miso.rvalid},
                         {awq.size() != 0, wq.size() != 0, bq.size() != 0, arq.size() != 0, rq.size() != 0});
            end
            n_checks++;
            if ((awq.size() != 0 && m_mosi.aw !== awq[0]) || (wq.size() != 0 && m_mosi.w !== wq[0]) ||
                (bq.size() != 0 && s_miso.b !== bq[0]) || (arq.size() != 0 && m_mosi.ar !== arq[0]) ||
                (rq.size() != 0 && s_miso.r !== rq[0])) begin
                n_errors++;
                $display("FAIL rnd_payload c=%0d got aw=%0h w=%0h b=%0h ar=%0h r=%0h (head order broken)",
                         c, m_mosi.aw, m_mosi.w, s_miso.b, m_mosi.ar, s_miso.r);
            end
            n_checks++;
            if (wr_ot !== 8'(wr_m) || rd_ot !== 8'(rd_m) ||
                idle !== (awq.size() == 0 && wq.size() == 0 && bq.size() == 0 && arq.size() == 0 &&
                          rq.size() == 0 && wr_m == 0 && rd_m == 0)) begin
                n_errors++;
                $display("FAIL rnd_ot c=%0d got wr=%0d rd=%0d idle=%b exp wr=%0d rd=%0d", c, wr_ot, rd_ot, idle, wr_m, rd_m);
            end
            if (!aw_p && $urandom_range(0, 1) == 1) begin t = {$urandom(), $urandom()}; aw_v = t[$bits(axi_aw_pld_t)-1:0]; aw_p = 1; end
            if (!w_p  && $urandom_range(0, 1) == 1) begin t = {$urandom(), $urandom()}; w_v  = t[$bits(axi_w_pld_t)-1:0];  w_p  = 1; end
            if (!b_p  && $urandom_range(0, 2) == 0) begin t = {$urandom(), $urandom()}; b_v  = t[$bits(axi_b_pld_t)-1:0];  b_p  = 1; end
            if (!ar_p && $urandom_range(0, 1) == 1) begin t = {$urandom(), $urandom()}; ar_v = t[$bits(axi_ar_pld_t)-1:0]; ar_p = 1; end
            if (!r_p  && $urandom_range(0, 1) == 1) begin t = {$urandom(), $urandom()}; r_v  = t[$bits(axi_r_pld_t)-1:0];  r_p  = 1; end
            s_mosi.awvalid = aw_p; s_mosi.aw = aw_v;
            s_mosi.wvalid  = w_p;  s_mosi.w  = w_v;
            m_miso.bvalid  = b_p;  m_miso.b  = b_v;
            s_mosi.arvalid = ar_p; s_mosi.ar = ar_v;
            m_miso.rvalid  = r_p;  m_miso.r  = r_v;
            m_miso.awready = ($urandom_range(0, 3) != 0);
            m_miso.wready  = ($urandom_range(0, 3) != 0);
            s_mosi.bready  = ($urandom_range(0, 3) != 0);
            m_miso.arready = ($urandom_range(0, 3) != 0);
            s_mosi.rready  = ($urandom_range(0, 3) != 0);
            h_aw = aw_p && e_awr; h_w = w_p && e_wr; h_b = b_p && e_br; h_ar = ar_p && e_arr; h_r = r_p && e_rr;
            h_bu = (bq.size() != 0) && s_mosi.bready;
            h_ru = (rq.size() != 0) && s_mosi.rready && rq[0].rlast;
            if (h_aw && !h_bu && wr_m < 255) wr_m++;
            else if (h_bu && !h_aw && wr_m > 0) wr_m--;
            if (h_ar && !h_ru && rd_m < 255) rd_m++;
            else if (h_ru && !h_ar && rd_m > 0) rd_m--;
            if (awq.size() != 0 && m_miso.awready) void'(awq.pop_front());
            if (wq.size()  != 0 && m_miso.wready)  void'(wq.pop_front());
            if (h_bu) void'(bq.pop_front());
            if (arq.size() != 0 && m_miso.arready) void'(arq.pop_front());
            if (rq.size()  != 0 && s_mosi.rready)  void'(rq.pop_front());
            if (h_aw) begin awq.push_back(aw_v); aw_p = 0; end
            if (h_w)  begin wq.push_back(w_v);   w_p  = 0; end
            if (h_b)  begin bq.push_back(b_v);   b_p  = 0; end
            if (h_ar) begin arq.push_back(ar_v); ar_p = 0; end
            if (h_r)  begin rq.push_back(r_v);   r_p  = 0; end
            cyc();
        end
    endtask

    initial begin
        s_mosi = '0;
        m_miso = '0;
        rst = 1'b0;
        #2;
        test_reset();
        test_throughput();
        test_backpressure();
        test_ot_limit();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
